// File: rtl/fuzz_sig_pkg.sv
// Shared types and the MISR update rule for the signature collector.
package fuzz_sig_pkg;

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_e;

  localparam int              DEF_SIG_W  = 16;
  localparam int              DEF_DATA_W = 8;
  localparam logic [15:0]     DEF_POLY   = 16'h1021;
  localparam logic [15:0]     DEF_SEED   = 16'hFFFF;

  // One MISR step: shift left, fold the polynomial back in when the MSB
  // falls out, then mix in the (already zero-extended) sample.
  function automatic logic [DEF_SIG_W-1:0] misr_next(
    input logic [DEF_SIG_W-1:0] sig,
    input logic [DEF_SIG_W-1:0] data,
    input logic [DEF_SIG_W-1:0] poly
  );
    return {sig[DEF_SIG_W-2:0], 1'b0} ^ (sig[DEF_SIG_W-1] ? poly : '0) ^ data;
  endfunction

endpackage

// File: rtl/fuzz_sig_misr.sv
// Registered MISR plus per-bit seen-0/seen-1 tracking and toggle mask.
module fuzz_sig_misr
  import fuzz_sig_pkg::*;
#(
  parameter int               DATA_W = DEF_DATA_W,
  parameter int               SIG_W  = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  sig,
  output logic [DATA_W-1:0] mask
);

  logic [SIG_W-1:0]  data_ext;
  logic [SIG_W-1:0]  sig_nxt;
  logic [DATA_W-1:0] seen0, seen1;
  logic [DATA_W-1:0] seen0_nxt, seen1_nxt;

  assign data_ext  = SIG_W'(data);
  assign seen0_nxt = seen0 | ~data;
  assign seen1_nxt = seen1 | data;

  // The package step function is fixed at the default width; other widths
  // use the same equation written out generically.
  generate
    if (SIG_W == DEF_SIG_W) begin : g_pkg_step
      assign sig_nxt = misr_next(sig, data_ext, POLY);
    end else begin : g_gen_step
      assign sig_nxt = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ data_ext;
    end
  endgenerate

  // Signature/coverage state: cleared on reset or load, advanced per sample.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig   <= SEED;
      seen0 <= '0;
      seen1 <= '0;
      mask  <= '0;
    end else if (en) begin
      sig   <= sig_nxt;
      seen0 <= seen0_nxt;
      seen1 <= seen1_nxt;
      mask  <= seen0_nxt & seen1_nxt;
    end
  end

endmodule

// File: rtl/fuzz_sig_collector.sv
// Windowed signature collector: FSM and sample counter around the MISR.
module fuzz_sig_collector
  import fuzz_sig_pkg::*;
#(
  parameter int               DATA_W = DEF_DATA_W,
  parameter int               SIG_W  = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED   = DEF_SEED,
  parameter int               CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic [SIG_W-1:0]  sig_out,
  output logic [DATA_W-1:0] toggle_mask,
  output logic [CNT_W-1:0]  sample_count,
  output logic              done_valid,
  input  logic              done_ready
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q;
  logic             load, en;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, MISR load/enable strobes and status outputs.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    en         = 1'b0;
    busy       = (state_q != IDLE);
    done_valid = (state_q == REPORT);
    case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        state_d = (num_samples == '0) ? REPORT : RUN;
      end
      RUN: if (in_valid) begin
        en = 1'b1;
        // target >= 1 here, so target-1 never underflows.
        if (sample_count == target_q - CNT_W'(1)) state_d = REPORT;
      end
      REPORT: if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window length latch and accepted-sample counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q     <= '0;
      sample_count <= '0;
    end else if (load) begin
      target_q     <= num_samples;
      sample_count <= '0;
    end else if (en) begin
      sample_count <= sample_count + CNT_W'(1);
    end
  end

  fuzz_sig_misr #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (en),
    .data (in_data),
    .sig  (sig_out),
    .mask (toggle_mask)
  );

endmodule

// File: tb/tb_fuzz_sig_collector.sv
// Self-checking bench for fuzz_sig_collector with a behavioural window model.
module tb_fuzz_sig_collector;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, done_ready;
  logic [15:0] num_samples;
  logic [7:0]  in_data;
  logic        busy, done_valid;
  logic [15:0] sig_out, sample_count;
  logic [7:0]  toggle_mask;

  int checks   = 0;
  int failures = 0;

  // Reference window state: signature by arithmetic, coverage as OR/AND of samples.
  logic [15:0] m_sig;
  logic [7:0]  m_or, m_and;
  int          m_cnt;

  always #5 clk = ~clk;

  fuzz_sig_collector dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .busy         (busy),
    .sig_out      (sig_out),
    .toggle_mask  (toggle_mask),
    .sample_count (sample_count),
    .done_valid   (done_valid),
    .done_ready   (done_ready)
  );

  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [7:0] d);
    int unsigned v;
    v = 32'(s) * 2;
    if (v >= 65536) v = (v - 65536) ^ 32'h1021;
    return v[15:0] ^ {8'h00, d};
  endfunction

  task automatic model_open();
    m_sig = 16'hFFFF; m_or = 8'h00; m_and = 8'hFF; m_cnt = 0;
  endtask

  task automatic model_sample(input logic [7:0] d);
    m_sig = ref_step(m_sig, d); m_or |= d; m_and &= d; m_cnt++;
  endtask

  function automatic logic [7:0] model_mask();
    return (m_cnt == 0) ? 8'h00 : (m_or & ~m_and);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0; in_data = '0; done_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b want=0", done_valid); end
    checks++; if (sig_out !== 16'hFFFF) begin failures++; $display("FAIL reset_sig got=%h want=ffff", sig_out); end
    checks++; if (toggle_mask !== 8'h00) begin failures++; $display("FAIL reset_mask got=%h want=00", toggle_mask); end
    checks++; if (sample_count !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", sample_count); end
  endtask

  task automatic test_single();
    @(negedge clk); start = 1'b1; num_samples = 16'd1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL single_early_dv got=%b want=0", done_valid); end
    @(negedge clk); in_valid = 1'b0;
    checks++; if (done_valid !== 1'b1) begin failures++; $display("FAIL single_dv got=%b want=1", done_valid); end
    checks++; if (sig_out !== 16'hEF7A) begin failures++; $display("FAIL single_sig got=%h want=ef7a", sig_out); end
    checks++; if (sample_count !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d want=1", sample_count); end
    checks++; if (toggle_mask !== 8'h00) begin failures++; $display("FAIL single_mask got=%h want=00", toggle_mask); end
    done_ready = 1'b1;
    @(negedge clk); done_ready = 1'b0;
    checks++; if (done_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_ack dv=%b busy=%b want 0/0", done_valid, busy); end
    checks++; if (sig_out !== 16'hEF7A) begin failures++; $display("FAIL single_hold got=%h want=ef7a", sig_out); end
  endtask

  task automatic test_gap();
    @(negedge clk); start = 1'b1; num_samples = 16'd2;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'h00;
    @(negedge clk); in_valid = 1'b0; in_data = 8'h5A;
    checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL gap_dv1 got=%b want=0", done_valid); end
    @(negedge clk); in_valid = 1'b1; in_data = 8'h00;
    checks++; if (done_valid !== 1'b0 || sample_count !== 16'd1) begin failures++; $display("FAIL gap_mid dv=%b cnt=%0d want 0/1", done_valid, sample_count); end
    @(negedge clk); in_valid = 1'b0;
    checks++; if (done_valid !== 1'b1) begin failures++; $display("FAIL gap_dv2 got=%b want=1", done_valid); end
    checks++; if (sig_out !== 16'hCF9F) begin failures++; $display("FAIL gap_sig got=%h want=cf9f", sig_out); end
    done_ready = 1'b1;
    @(negedge clk); done_ready = 1'b0;
  endtask

  task automatic test_toggle();
    model_open(); model_sample(8'h0F); model_sample(8'hF0);
    @(negedge clk); start = 1'b1; num_samples = 16'd2;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'h0F;
    @(negedge clk); in_data = 8'hF0;
    @(negedge clk); in_valid = 1'b0;
    checks++; if (toggle_mask !== 8'hFF) begin failures++; $display("FAIL toggle_mask got=%h want=ff", toggle_mask); end
    checks++; if (sample_count !== 16'd2) begin failures++; $display("FAIL toggle_cnt got=%0d want=2", sample_count); end
    checks++; if (sig_out !== m_sig) begin failures++; $display("FAIL toggle_sig got=%h want=%h", sig_out, m_sig); end
    done_ready = 1'b1;
    @(negedge clk); done_ready = 1'b0;
  endtask

  task automatic test_empty();
    @(negedge clk); start = 1'b1; num_samples = 16'd0; in_valid = 1'b1; in_data = 8'h33;
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
    checks++; if (done_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL empty_dv dv=%b busy=%b want 1/1", done_valid, busy); end
    checks++; if (sig_out !== 16'hFFFF) begin failures++; $display("FAIL empty_sig got=%h want=ffff", sig_out); end
    checks++; if (sample_count !== 16'd0) begin failures++; $display("FAIL empty_cnt got=%0d want=0", sample_count); end
    done_ready = 1'b1;
    @(negedge clk); done_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk); start = 1'b1; num_samples = 16'd1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'($urandom); start = i[0]; num_samples = 16'd3; done_ready = 1'b0;
      checks++;
      if (done_valid !== 1'b1 || busy !== 1'b1 || sig_out !== 16'hEF7A || sample_count !== 16'd1 || toggle_mask !== 8'h00) begin
        failures++;
        $display("FAIL hold_%0d dv=%b busy=%b sig=%h cnt=%0d mask=%h want 1/1/ef7a/1/00", i, done_valid, busy, sig_out, sample_count, toggle_mask);
      end
    end
    @(negedge clk); in_valid = 1'b0; done_ready = 1'b1; start = 1'b1; num_samples = 16'd3;
    @(negedge clk); done_ready = 1'b0; start = 1'b0;
    checks++; if (done_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_ack dv=%b busy=%b want 0/0", done_valid, busy); end
    checks++; if (sig_out !== 16'hEF7A) begin failures++; $display("FAIL bp_hold got=%h want=ef7a", sig_out); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_start_ignored busy=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); start = 1'b1; num_samples = 16'd10;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || sig_out !== 16'hFFFF || sample_count !== 16'd0 || done_valid !== 1'b0 || toggle_mask !== 8'h00) begin
      failures++;
      $display("FAIL midrst busy=%b sig=%h cnt=%0d dv=%b mask=%h want 0/ffff/0/0/00", busy, sig_out, sample_count, done_valid, toggle_mask);
    end
    @(negedge clk); start = 1'b1; num_samples = 16'd1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk); in_valid = 1'b0;
    checks++; if (done_valid !== 1'b1 || sig_out !== 16'hEF7A) begin failures++; $display("FAIL midrst_rerun dv=%b sig=%h want 1/ef7a", done_valid, sig_out); end
    done_ready = 1'b1;
    @(negedge clk); done_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int w = 0; w < 8; w++) begin
      int n, iter;
      n = $urandom_range(1, 12);
      model_open();
      @(negedge clk); start = 1'b1; num_samples = 16'(n);
      @(negedge clk); start = 1'b0;
      iter = 0;
      while (m_cnt < n) begin
        logic v;
        logic [7:0] d;
        checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_early_dv at %0d got=%b want=0", w, m_cnt, done_valid); end
        v = ($urandom_range(0, 2) != 0);
        d = 8'($urandom);
        in_valid = v; in_data = d;
        if (v) model_sample(d);
        @(negedge clk);
        iter++;
        if (iter > 200) begin failures++; $display("FAIL rnd%0d_budget iterations=%0d limit=200", w, iter); break; end
      end
      in_valid = 1'b0;
      checks++; if (done_valid !== 1'b1) begin failures++; $display("FAIL rnd%0d_dv got=%b want=1", w, done_valid); end
      checks++; if (sig_out !== m_sig) begin failures++; $display("FAIL rnd%0d_sig got=%h want=%h", w, sig_out, m_sig); end
      checks++; if (toggle_mask !== model_mask()) begin failures++; $display("FAIL rnd%0d_mask got=%h want=%h", w, toggle_mask, model_mask()); end
      checks++; if (sample_count !== 16'(m_cnt)) begin failures++; $display("FAIL rnd%0d_cnt got=%0d want=%0d", w, sample_count, m_cnt); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      done_ready = 1'b1;
      @(negedge clk); done_ready = 1'b0;
      checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_ack got=%b want=0", w, done_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_toggle();
    test_empty();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
